// File: rtl/tlc_top.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tlc_top
// Single-intersection traffic light controller. A Moore FSM steps through
// RED -> GREEN -> YELLOW -> RED. Each phase lasts a fixed number of timebase
// ticks, and the ticks come from an internal clock prescaler.
//
// Parameters:
//   RED_TICKS    ticks spent in RED    (>= 1)
//   GREEN_TICKS  ticks spent in GREEN  (>= 1)
//   YELLOW_TICKS ticks spent in YELLOW (>= 1)
//   TICK_DIV     clock cycles per tick (>= 1, 1 = tick every clock)
//
// Ports:
//   clk     in   system clock, rising-edge active
//   rst     in   asynchronous active-high reset, forces RED at once
//   red     out  red lamp drive, high while in RED
//   yellow  out  yellow lamp drive, high while in YELLOW
//   green   out  green lamp drive, high while in GREEN
// -----------------------------------------------------------------------------
module tlc_top #(
  parameter int RED_TICKS    = 10,
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int TICK_DIV     = 1
) (
  input  logic clk,
  input  logic rst,
  output logic red,
  output logic yellow,
  output logic green
);

  // Longest phase sets the phase counter width.
  localparam int MAX_RG    = (RED_TICKS > GREEN_TICKS) ? RED_TICKS : GREEN_TICKS;
  localparam int MAX_TICKS = (MAX_RG > YELLOW_TICKS) ? MAX_RG : YELLOW_TICKS;
  localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam int PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_TICKS - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);

  // 2'b11 is unreachable; the next-state logic sends it back to RED.
  typedef enum logic [1:0] {
    S_RED    = 2'b00,
    S_GREEN  = 2'b01,
    S_YELLOW = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] last_cnt;
  logic             tick;
  logic             red_q, yellow_q, green_q;

  // ---------------------------------------------------------------------------
  // Prescaler: free-running 0..TICK_DIV-1. The tick is the terminal count.
  // With TICK_DIV=1 the counter is a constant zero and tick is always high.
  // ---------------------------------------------------------------------------
  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Phase sequencing.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    last_cnt = RED_LAST;
    case (state_q)
      S_RED: begin
        last_cnt = RED_LAST;
        if (tick) begin
          if (count_q == last_cnt) begin
            state_d = S_GREEN;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      S_GREEN: begin
        last_cnt = GREEN_LAST;
        if (tick) begin
          if (count_q == last_cnt) begin
            state_d = S_YELLOW;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      S_YELLOW: begin
        last_cnt = YELLOW_LAST;
        if (tick) begin
          if (count_q == last_cnt) begin
            state_d = S_RED;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: begin
        // Corrupted encoding: recover on the next edge, whether or not a tick
        // is present, and restart the RED phase from the beginning.
        state_d = S_RED;
        count_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counters and lamp registers. The lamps are a decode of the next
  // state, so they always match state_q one-hot and no lamp glitches. state_d
  // is never the unreachable encoding, so exactly one lamp is high.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_RED;
      count_q  <= '0;
      pre_q    <= '0;
      red_q    <= 1'b1;
      yellow_q <= 1'b0;
      green_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      pre_q    <= pre_d;
      red_q    <= (state_d == S_RED);
      yellow_q <= (state_d == S_YELLOW);
      green_q  <= (state_d == S_GREEN);
    end
  end

  assign red    = red_q;
  assign yellow = yellow_q;
  assign green  = green_q;

endmodule

// File: tb/tb_tlc_top.sv
`timescale 1ns/1ps
module tb_tlc_top;

  localparam logic [2:0] L_RED = 3'b100;  // {red, yellow, green}
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic d_red, d_yel, d_grn;   // defaults 10/8/3, div 1
  logic v_red, v_yel, v_grn;   // 2/1/1, div 2
  logic o_red, o_yel, o_grn;   // 1/1/1, div 1

  tlc_top u_def (
    .clk(clk), .rst(rst), .red(d_red), .yellow(d_yel), .green(d_grn)
  );

  tlc_top #(
    .RED_TICKS(2), .GREEN_TICKS(1), .YELLOW_TICKS(1), .TICK_DIV(2)
  ) u_div (
    .clk(clk), .rst(rst), .red(v_red), .yellow(v_yel), .green(v_grn)
  );

  tlc_top #(
    .RED_TICKS(1), .GREEN_TICKS(1), .YELLOW_TICKS(1), .TICK_DIV(1)
  ) u_one (
    .clk(clk), .rst(rst), .red(o_red), .yellow(o_yel), .green(o_grn)
  );

  always #1 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference: the number of clock edges seen since reset was released.
  int t_model = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) t_model <= 0;
    else     t_model <= t_model + 1;
  end

  // Expected lamps after t edges. The position inside one full period picks
  // the phase.
  function automatic logic [2:0] ref_lamps(int t, int r, int g, int y, int d);
    int pos;
    pos = t % ((r + g + y) * d);
    if (pos < r * d)            return L_RED;
    else if (pos < (r + g) * d) return L_GRN;
    else                        return L_YEL;
  endfunction

  task automatic cmp(string name, logic [2:0] got, logic [2:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %b want %b (t=%0d, time %0t)", name, got, want, t_model, $time);
    end
  endtask

  task automatic check_model();
    cmp("model_def", {d_red, d_yel, d_grn}, ref_lamps(t_model, 10, 8, 3, 1));
    cmp("model_div", {v_red, v_yel, v_grn}, ref_lamps(t_model, 2, 1, 1, 2));
    cmp("model_one", {o_red, o_yel, o_grn}, ref_lamps(t_model, 1, 1, 1, 1));
  endtask

  task automatic step(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_model();
    end
  endtask

  typedef struct {
    logic       rst;
    int         clocks;
    logic [2:0] exp_def;
    logic [2:0] exp_div;
    logic [2:0] exp_one;
  } vec_t;

  vec_t tbl [13];

  function automatic logic [2:0] succ(logic [2:0] l);
    if (l == L_RED)      return L_GRN;
    else if (l == L_GRN) return L_YEL;
    else                 return L_RED;
  endfunction

  initial begin
    logic [2:0] prev, cur;
    int periods;

    // Hand-derived expectations at cumulative edge counts since release.
    tbl[0]  = '{1'b0, 0, L_RED, L_RED, L_RED};  // t=0
    tbl[1]  = '{1'b0, 9, L_RED, L_RED, L_RED};  // t=9
    tbl[2]  = '{1'b0, 1, L_GRN, L_RED, L_GRN};  // t=10
    tbl[3]  = '{1'b0, 7, L_GRN, L_RED, L_YEL};  // t=17
    tbl[4]  = '{1'b0, 1, L_YEL, L_RED, L_RED};  // t=18
    tbl[5]  = '{1'b0, 2, L_YEL, L_GRN, L_YEL};  // t=20
    tbl[6]  = '{1'b0, 1, L_RED, L_GRN, L_RED};  // t=21
    tbl[7]  = '{1'b0, 2, L_RED, L_YEL, L_YEL};  // t=23
    tbl[8]  = '{1'b0, 1, L_RED, L_RED, L_RED};  // t=24
    tbl[9]  = '{1'b1, 1, L_RED, L_RED, L_RED};  // held in reset
    tbl[10] = '{1'b0, 0, L_RED, L_RED, L_RED};  // t=0
    tbl[11] = '{1'b0, 4, L_RED, L_GRN, L_GRN};  // t=4
    tbl[12] = '{1'b0, 2, L_RED, L_YEL, L_RED};  // t=6

    // Power-on reset: asserted before the first edge, held across it.
    #0.2 rst = 1'b1;
    #0.2;
    cmp("por_def", {d_red, d_yel, d_grn}, L_RED);
    cmp("por_div", {v_red, v_yel, v_grn}, L_RED);
    cmp("por_one", {o_red, o_yel, o_grn}, L_RED);
    @(negedge clk);
    cmp("por_hold_def", {d_red, d_yel, d_grn}, L_RED);
    cmp("por_hold_one", {o_red, o_yel, o_grn}, L_RED);

    // Table-driven vectors.
    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst;
      #0.1;
      step(tbl[i].clocks);
      cmp($sformatf("tbl%0d_def", i), {d_red, d_yel, d_grn}, tbl[i].exp_def);
      cmp($sformatf("tbl%0d_div", i), {v_red, v_yel, v_grn}, tbl[i].exp_div);
      cmp($sformatf("tbl%0d_one", i), {o_red, o_yel, o_grn}, tbl[i].exp_one);
    end

    // Asynchronous reset in the middle of GREEN, between clock edges.
    step(6);  // t=12: default instance is in GREEN
    cmp("pre_async_def", {d_red, d_yel, d_grn}, L_GRN);
    #0.5 rst = 1'b1;
    #0.1;
    cmp("async_def", {d_red, d_yel, d_grn}, L_RED);
    cmp("async_div", {v_red, v_yel, v_grn}, L_RED);
    cmp("async_one", {o_red, o_yel, o_grn}, L_RED);
    @(negedge clk);
    rst = 1'b0;
    step(9);
    cmp("restart_red_last", {d_red, d_yel, d_grn}, L_RED);
    step(1);
    cmp("restart_green", {d_red, d_yel, d_grn}, L_GRN);

    // Long clean run: order never deviates, count the completed periods.
    rst = 1'b1;
    #0.1;
    @(negedge clk);
    rst = 1'b0;
    prev = {d_red, d_yel, d_grn};
    periods = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      cur = {d_red, d_yel, d_grn};
      if (cur != prev) begin
        cmp("order", cur, succ(prev));
        if (prev == L_YEL) periods++;
      end
      prev = cur;
    end
    vectors++;
    if (periods != 47) begin
      miscompares++;
      $display("FAIL period_count: got %0d want 47", periods);
    end

    // Randomized reset pulses, including some between edges.
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 3) begin
        #0.5 rst = 1'b1;
        #0.1;
        check_model();
      end
      step(1);
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tlc_top.md
Name: tlc_top

Overview:
Single-intersection traffic light controller producing one-hot red/yellow/green lamp drives. It is a Moore FSM that sequences RED -> GREEN -> YELLOW -> RED. Each phase lasts a parameterised number of timebase ticks, and ticks come from an internal clock prescaler. It is the top-level controller block; lamp outputs go directly to output drivers.

Parameters:
RED_TICKS, 10, duration of RED phase in ticks (legal range >=1)
GREEN_TICKS, 8, duration of GREEN phase in ticks (legal range >=1)
YELLOW_TICKS, 3, duration of YELLOW phase in ticks (legal range >=1)
TICK_DIV, 1, clock cycles per tick (legal range >=1; 1 means one tick per clock)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous active-high reset; forces RED immediately
red  output  1  red lamp, high while in RED
yellow  output  1  yellow lamp, high while in YELLOW
green  output  1  green lamp, high while in GREEN

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- All state is registered on the rising edge of clk, with asynchronous clear from rst.
- Reset values while rst=1 and immediately on assertion (no clock needed):
  - state = RED; red=1, yellow=0, green=0
  - phase counter = 0; prescaler counter = 0
- Outputs are a pure decode of the state register. Exactly one lamp is high at all times, including during reset. There are no glitches and no all-off cycles.
- Prescaler:
  - The prescaler counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick = 1 in the cycle where prescaler == TICK_DIV-1.
  - With TICK_DIV=1, tick is constantly 1.
  - Width is clog2(TICK_DIV), minimum 1 bit.
- Phase counter:
  - Width is clog2 of the maximum of the three durations, minimum 1 bit.
  - On a rising edge with tick=1: if count == DUR(state)-1, then state <= next(state) and count <= 0; otherwise count <= count+1.
  - On a rising edge with tick=0: count and state hold.
- State transitions: RED->GREEN, GREEN->YELLOW, YELLOW->RED. There are no other states.
  - Encoding is free, but any unreachable encoding must recover to RED on the next edge.
- Timing: each phase is visible for exactly DUR*TICK_DIV clock cycles.
  - After rst deasserts, red stays high for RED_TICKS*TICK_DIV rising edges.
  - green rises on the edge that completes the RED phase.
  - Full period = (RED_TICKS+GREEN_TICKS+YELLOW_TICKS)*TICK_DIV cycles.
- Reset mid-operation: at any phase or count, rst returns to RED with both counters 0. The RED phase then restarts at full length after release.
- Reset release: the first rising edge with rst=0 counts as the first clock of the RED phase.
- Durations of 1 are legal: the phase lasts exactly TICK_DIV cycles.

Test Plan:
- Power-on reset, defaults, 2 ns clock: rst=1 for 2 ns then 0 for 2 ns -> red=1, yellow=0, green=0 throughout; output never X after time 0 once rst has been asserted.
- Full cycle, defaults: release reset, run 21 clocks. Required:
  - red=1 for clocks 1-10
  - green=1 for clocks 11-18
  - yellow=1 for clocks 19-21
  - red=1 again at clock 22
  - one-hot checked every cycle
- TICK_DIV=2, durations 2/1/1: after release, red for 4 clocks, green for 2, yellow for 2, then red. Period is 8 clocks.
- Asynchronous reset mid-GREEN: assert rst between clock edges during green -> red=1 and green=0 immediately, before the next edge. After release, the full 10-clock RED phase is repeated.
- All durations=1, TICK_DIV=1: lamps rotate red, green, yellow, red on every clock. Period is 3 clocks.
- Long run of 1000 clocks with defaults: exactly one lamp high every cycle. The sequence order never deviates, and there are 47 full periods plus partial phases.
